// File: rtl/tick_pkg.sv
// tick_pkg: shared constants for the tick selector.
// FSM state encoding, default sizing and channel indices.
package tick_pkg;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  localparam int NUM_CH_DEF     = 4;
  localparam int DEFAULT_CH_DEF = 1;

  localparam int CH_05HZ = 0;
  localparam int CH_1HZ  = 1;
  localparam int CH_2HZ  = 2;
  localparam int CH_10HZ = 3;

endpackage

// File: rtl/tick_auto_seq.sv
// tick_auto_seq: auto-mode channel sequencer (auto_idx, auto_cnt).
// Ports: clk, rst, auto_en, auto_period, fwd (tick_out), pending, sel_active -> auto_req.
import tick_pkg::*;

module tick_auto_seq #(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int SEL_W      = $clog2(NUM_CH),
  parameter int DEFAULT_CH = DEFAULT_CH_DEF,
  parameter int AUTO_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              auto_en,
  input  logic [AUTO_W-1:0] auto_period,
  input  logic              fwd,
  input  logic              pending,
  input  logic [SEL_W-1:0]  sel_active,
  output logic [SEL_W-1:0]  auto_req
);

  logic              en_q;
  logic [SEL_W-1:0]  auto_idx;
  logic [AUTO_W-1:0] auto_cnt;
  logic [AUTO_W-1:0] last;
  logic              rise;
  logic              fall;
  logic              inc;

  assign rise = auto_en & ~en_q;
  assign fall = ~auto_en & en_q;
  assign inc  = auto_en & en_q & fwd & ~pending;

  // period 0 behaves as period 1
  assign last = (auto_period == '0) ? '0
              : auto_period - 1'b1;

  // on the enabling cycle request the live channel so no switch starts
  assign auto_req = rise ? sel_active : auto_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      auto_idx <= SEL_W'(DEFAULT_CH);
      auto_cnt <= '0;
    end else begin
      en_q <= auto_en;
      unique case (1'b1)
        rise: begin
          auto_idx <= sel_active;
          auto_cnt <= '0;
        end
        fall: auto_cnt <= '0;
        inc: begin
          if (auto_cnt >= last) begin
            auto_cnt <= '0;
            auto_idx <= (auto_idx == SEL_W'(NUM_CH - 1))
                      ? '0 : auto_idx + 1'b1;
          end else begin
            auto_cnt <= auto_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tick_sel_sync.sv
// tick_sel_sync: N-channel tick selector, switches only on active-channel ticks.
// Ports: clk, rst, tick_in, sel_manual, auto_en, auto_period -> tick_out, sel_active,
// sel_changed, pending. Optional macro TICK_SEL_TIMEOUT_EN forces stalled switches.
import tick_pkg::*;

module tick_sel_sync #(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int SEL_W       = $clog2(NUM_CH),
  parameter int DEFAULT_CH  = DEFAULT_CH_DEF,
  parameter int AUTO_W      = 8,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] tick_in,
  input  logic [SEL_W-1:0]  sel_manual,
  input  logic              auto_en,
  input  logic [AUTO_W-1:0] auto_period,
  output logic              tick_out,
  output logic [SEL_W-1:0]  sel_active,
  output logic              sel_changed,
  output logic              pending
);

  logic [0:0]       state;
  logic [SEL_W-1:0] auto_req;
  logic [SEL_W-1:0] req_raw;
  logic [SEL_W-1:0] req;
  logic             act_tick;
  logic             tmo_hit;

  tick_auto_seq #(
    .NUM_CH     (NUM_CH),
    .SEL_W      (SEL_W),
    .DEFAULT_CH (DEFAULT_CH),
    .AUTO_W     (AUTO_W)
  ) u_auto (
    .clk         (clk),
    .rst         (rst),
    .auto_en     (auto_en),
    .auto_period (auto_period),
    .fwd         (tick_out),
    .pending     (pending),
    .sel_active  (sel_active),
    .auto_req    (auto_req)
  );

  assign req_raw = auto_en ? auto_req : sel_manual;
  assign req = ({1'b0, req_raw} >= (SEL_W+1)'(NUM_CH))
             ? SEL_W'(DEFAULT_CH) : req_raw;

  assign act_tick = tick_in[sel_active];
  assign pending  = (state == ST_PEND);

`ifdef TICK_SEL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = pending
                 & (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  // counts stalled PEND cycles, cleared whenever PEND resolves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (pending && req != sel_active
                 && !act_tick && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      sel_active  <= SEL_W'(DEFAULT_CH);
      tick_out    <= 1'b0;
      sel_changed <= 1'b0;
    end else begin
      // the switch tick still comes from the old channel
      tick_out    <= act_tick;
      sel_changed <= 1'b0;
      unique case (state)
        ST_RUN: begin
          if (req != sel_active) state <= ST_PEND;
        end
        ST_PEND: begin
          if (req == sel_active) begin
            state <= ST_RUN;
          end else if (act_tick || tmo_hit) begin
            sel_active  <= req;
            sel_changed <= 1'b1;
            state       <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_sel_sync.sv
// tb_tick_sel_sync: directed + random check of tick_sel_sync against a reference model.
// A second instance with NUM_CH=3 covers out-of-range selection.
module tb_tick_sel_sync;

  localparam int NCH = 4;
  localparam int DEF = 1;
  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] tick_in = '0;
  logic [1:0] sel_manual = 2'd1;
  logic [1:0] sel3 = 2'd3;
  logic       auto_en = 1'b0;
  logic [7:0] auto_period = '0;

  logic       tick_out, sel_changed, pending;
  logic [1:0] sel_active;
  logic       tick_out3, sel_changed3, pending3;
  logic [1:0] sel_active3;

  int n_chk = 0;
  int n_fail = 0;

  int m_sel, m_out, m_chg, m_pend;
  int m_idx, m_cnt, m_aq, m_tmo;

  always #5 clk = ~clk;

  tick_sel_sync #(
    .NUM_CH(NCH), .DEFAULT_CH(DEF),
    .AUTO_W(8), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in),
    .sel_manual(sel_manual), .auto_en(auto_en),
    .auto_period(auto_period), .tick_out(tick_out),
    .sel_active(sel_active), .sel_changed(sel_changed),
    .pending(pending)
  );

  tick_sel_sync #(
    .NUM_CH(3), .DEFAULT_CH(DEF),
    .AUTO_W(8), .TIMEOUT_CYC(TMO)
  ) dut3 (
    .clk(clk), .rst(rst), .tick_in(tick_in[2:0]),
    .sel_manual(sel3), .auto_en(1'b0),
    .auto_period(8'd0), .tick_out(tick_out3),
    .sel_active(sel_active3), .sel_changed(sel_changed3),
    .pending(pending3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel = DEF; m_out = 0; m_chg = 0; m_pend = 0;
    m_idx = DEF; m_cnt = 0; m_aq = 0; m_tmo = 0;
  endtask

  // one clock: predict from inputs, clock, compare at negedge
  task automatic step();
    int req, act, per;
    int n_sel, n_out, n_chg, n_pend, n_idx, n_cnt, n_tmo;
    bit rise, fall;
    rise = auto_en && (m_aq == 0);
    fall = !auto_en && (m_aq == 1);
    if (!auto_en) req = int'(sel_manual);
    else if (rise) req = m_sel;
    else req = m_idx;
    if (req >= NCH) req = DEF;
    act = int'(tick_in[m_sel]);
    n_sel = m_sel; n_out = act; n_chg = 0;
    n_pend = m_pend; n_tmo = 0;
    if (m_pend == 0) begin
      n_pend = (req != m_sel) ? 1 : 0;
    end else if (req == m_sel) begin
      n_pend = 0;
    end else if (act == 1) begin
      n_sel = req; n_chg = 1; n_pend = 0;
    end else begin
      n_tmo = m_tmo + 1;
`ifdef TICK_SEL_TIMEOUT_EN
      if (n_tmo == TMO) begin
        n_sel = req; n_chg = 1; n_pend = 0; n_tmo = 0;
      end
`endif
    end
    n_idx = m_idx; n_cnt = m_cnt;
    per = (auto_period == 0) ? 1 : int'(auto_period);
    if (rise) begin
      n_idx = m_sel; n_cnt = 0;
    end else if (fall) begin
      n_cnt = 0;
    end else if (auto_en && m_out == 1 && m_pend == 0) begin
      if (m_cnt + 1 >= per) begin
        n_cnt = 0; n_idx = (m_idx + 1) % NCH;
      end else begin
        n_cnt = m_cnt + 1;
      end
    end
    @(posedge clk);
    m_sel = n_sel; m_out = n_out; m_chg = n_chg;
    m_pend = n_pend; m_idx = n_idx; m_cnt = n_cnt;
    m_tmo = n_tmo; m_aq = auto_en ? 1 : 0;
    @(negedge clk);
    chk("tick_out", tick_out, m_out);
    chk("sel_active", sel_active, m_sel);
    chk("sel_changed", sel_changed, m_chg);
    chk("pending", pending, m_pend);
    if (sel3 == 2'd3) begin
      chk("oor_sel", sel_active3, DEF);
      chk("oor_pend", pending3, 0);
    end
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_tick_out", tick_out, 0);
    chk("rst_sel", sel_active, DEF);
    chk("rst_pend", pending, 0);
    chk("rst_chg", sel_changed, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [3:0] rnd_ticks();
    logic [3:0] t;
    for (int i = 0; i < 4; i++)
      t[i] = ($urandom_range(0, 2) == 0);
    return t;
  endfunction

  task automatic run_until(input string tag, input int target,
                           input int budget);
    int k;
    k = 0;
    while (int'(sel_active) != target && k < budget) begin
      tick_in = rnd_ticks();
      step();
      k++;
    end
    chk(tag, sel_active, target);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_tick_out", tick_out, 0);
    chk("init_sel", sel_active, DEF);
    chk("init_chg", sel_changed, 0);
    chk("init_pend", pending, 0);
    rst = 1'b0;

    tick_in = 4'b0010; step();
    chk("lat_one", tick_out, 1);
    tick_in = 4'b0000; step();
    chk("lat_zero", tick_out, 0);

    sel_manual = 2'd3; step();
    tick_in = 4'b0010; step();
    chk("pre_rst_sel", sel_active, 3);
    mid_reset();
    sel_manual = 2'd1; tick_in = 4'b0010; step();
    chk("post_rst_out", tick_out, 1);

    tick_in = 4'b0000; sel_manual = 2'd3;
    repeat (3) step();
    chk("defer_pend", pending, 1);
    chk("defer_hold", sel_active, 1);
    tick_in = 4'b1010; step();
    chk("defer_sel", sel_active, 3);
    chk("defer_chg", sel_changed, 1);
    chk("defer_fwd", tick_out, 1);
    tick_in = 4'b0000; step();
    chk("defer_nodup", tick_out, 0);
    chk("defer_once", sel_changed, 0);

    sel_manual = 2'd1; step();
    tick_in = 4'b1000; step();
    tick_in = 4'b0000; step();
    chk("back_sel", sel_active, 1);

    sel_manual = 2'd2; step(); step();
    chk("cancel_pend", pending, 1);
    sel_manual = 2'd1; step();
    chk("cancel_clr", pending, 0);
    chk("cancel_sel", sel_active, 1);
    chk("cancel_nochg", sel_changed, 0);

    sel_manual = 2'd3; step();
    tick_in = 4'b0010; step();
    tick_in = 4'b0000; step();
    auto_en = 1'b1; auto_period = 8'd3;
    step();
    chk("auto_nosw", pending, 0);
    run_until("auto_wrap", 0, 200);
    run_until("auto_next", 1, 200);
    auto_period = 8'd0;
    run_until("auto_p0", 2, 100);
    auto_en = 1'b0; sel_manual = 2'd0;
    run_until("auto_off", 0, 100);

    for (int c = 0; c < 600; c++) begin
      tick_in = rnd_ticks();
      if ($urandom_range(0, 9) == 0)
        sel_manual = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0)
        auto_en = ~auto_en;
      if ($urandom_range(0, 49) == 0)
        auto_period = 8'($urandom_range(0, 3));
      step();
    end

    auto_en = 1'b0;
    mid_reset();
    sel_manual = 2'd0; tick_in = 4'b0000; step();
    tick_in = 4'b0010; step();
    chk("tmo_start", sel_active, 0);
    sel_manual = 2'd2;
    for (int c = 0; c < TMO + 5; c++) begin
      tick_in = rnd_ticks() & 4'b1110;
      step();
    end
`ifdef TICK_SEL_TIMEOUT_EN
    chk("tmo_forced", sel_active, 2);
`else
    chk("tmo_hold", pending, 1);
`endif

    sel3 = 2'd2;
    begin
      int k;
      k = 0;
      while (sel_active3 != 2'd2 && k < 100) begin
        tick_in = rnd_ticks();
        step();
        k++;
      end
    end
    chk("oor_switch", sel_active3, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_sel_sync.md
Name: tick_sel_sync

Overview:
- Parametrised N-channel tick selector with glitch-safe switching and an automatic rate-cycling mode.
- Sits between the tick generator bank and the counter/display logic, and drives the single count-enable tick.
- Selection changes are deferred to a tick boundary of the active channel, so no tick is duplicated or lost at a switch.
- Auto mode steps through channels after a programmable number of forwarded ticks.

Parameters:
- NUM_CH, 4, number of tick input channels (2..16).
- SEL_W, $clog2(NUM_CH), selection width (derived; do not override).
- DEFAULT_CH, 1, channel used at reset and for out-of-range selections.
- AUTO_W, 8, width of the auto-mode period counter.
- TIMEOUT_CYC, 50_000_000, forced-switch timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick_in  in  NUM_CH  single-cycle tick pulses, one per channel, synchronous to clk.
- sel_manual  in  SEL_W  manual channel request (switches).
- auto_en  in  1  1 = auto-cycling mode, 0 = manual mode.
- auto_period  in  AUTO_W  forwarded ticks per channel in auto mode; 0 treated as 1.
- tick_out  out  1  registered selected tick.
- sel_active  out  SEL_W  channel currently forwarded.
- sel_changed  out  1  1-cycle pulse after sel_active updates.
- pending  out  1  a switch is requested but not yet applied.

Behaviour:
- Reset values: tick_out=0, sel_active=DEFAULT_CH, sel_changed=0, pending=0, auto_idx=DEFAULT_CH, auto_cnt=0, state=RUN.
- Latency: tick_out(t+1) = tick_in[sel_active](t). Exactly 1 cycle.
- Requested channel:
  - req = auto_en ? auto_idx : sel_manual.
  - If req >= NUM_CH, req = DEFAULT_CH.
- FSM with two states, RUN and PEND:
  - RUN: if req != sel_active, go to PEND with pending=1.
  - PEND: if req == sel_active, cancel and return to RUN with pending=0.
  - PEND: else, on a cycle with tick_in[sel_active]=1, forward that tick, load sel_active<=req, pulse sel_changed next cycle, and return to RUN.
  - A tick on the new channel in the switch cycle is not forwarded.
- A req change while in PEND retargets without restarting. The latest req at the switch cycle wins.
- Auto mode:
  - auto_cnt increments on each forwarded tick (tick_out=1).
  - When auto_cnt reaches max(auto_period,1)-1 on a forwarded tick, auto_cnt<=0 and auto_idx<=(auto_idx==NUM_CH-1)?0:auto_idx+1.
  - auto_cnt holds while pending=1.
- auto_en rising edge: auto_idx<=sel_active, auto_cnt<=0. No switch results.
- auto_en falling edge: auto_cnt<=0. req reverts to sel_manual, and a normal PEND switch follows if it differs.
- Simultaneous events:
  - An active tick in the same cycle as a req change into PEND counts as the switch tick only if the FSM is already in PEND.
  - The auto increment and the switch tick in the same cycle are both processed.
- rst mid-operation: all state returns to reset values immediately (async). Any in-flight tick is dropped.

Optional Feature:
- Macro: TICK_SEL_TIMEOUT_EN.
- Defined:
  - A timeout counter runs while in PEND.
  - After TIMEOUT_CYC cycles without an active-channel tick, the switch is forced: sel_active<=req, sel_changed pulses, tick_out stays 0 in that cycle.
  - The counter clears on leaving PEND.
  - Prevents multi-second stalls behind 0.5 Hz channels.
- Undefined: no counter, and PEND waits indefinitely for an active tick.

Decomposition:
- Shared package tick_pkg:
  - state encoding (ST_RUN, ST_PEND).
  - default NUM_CH and DEFAULT_CH constants.
  - channel index constants CH_05HZ=0, CH_1HZ=1, CH_2HZ=2, CH_10HZ=3.
- One sub-module, tick_auto_seq: owns auto_idx and auto_cnt and outputs the auto request. The main module holds the FSM and the output register.

Test Plan:
- Reset: assert rst mid-tick with sel_manual=3 → tick_out=0, sel_active=1, pending=0 asynchronously. After release, the 1 Hz ticks appear on tick_out 1 cycle later.
- Deferred switch: active ch1, set sel_manual=3 → pending=1 until the next tick_in[1]. That tick is forwarded, then sel_active=3 and sel_changed pulses once. A tick_in[3] in the switch cycle is not forwarded.
- Cancel: sel_manual 1→2→1 before any ch1 tick → pending returns to 0, sel_active stays 1, no sel_changed.
- Auto cycling: auto_en=1, auto_period=3, active ch3 → after 3 forwarded ticks, switch to ch0 (wrap). After 3 more, ch1. auto_period=0 advances after every tick.
- Out of range: NUM_CH=3, sel_manual=3 → req=DEFAULT_CH=1, and no switch occurs from ch1.
- Timeout (TICK_SEL_TIMEOUT_EN, TIMEOUT_CYC=20): ch0 silent, request ch2 → forced switch on cycle 20 of PEND with tick_out=0. Without the macro, pending holds.
